// File: rtl/uart_pkg.sv
// Shared definitions for the UART memory-dump transmitter: FSM encoding and 8N1 frame constants.
// DUMP_CHECKSUM_EN adds the CSUM state used to send the trailing XOR byte.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FETCH,
        ST_CAPTURE,
        ST_SEND,
        ST_NEXT,
        ST_FINISH
`ifdef DUMP_CHECKSUM_EN
        , ST_CSUM
`endif
    } dump_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serialiser with a valid/ready handshake; each bit is held for DIV clocks.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int DIV = 78
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 byte_valid,
    input  logic [DATA_BITS-1:0] byte_data,
    output logic                 byte_ready,
    output logic                 tx
);

    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    generate
        if (DIV < 2) begin : g_div_chk
            $error("uart_tx_byte: bit period DIV must be at least 2 clocks");
        end
    endgenerate

    logic                 active;
    logic [CNT_W-1:0]     cyc_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS:0]   shreg;   // data bits then stop bit, shifted out LSB first

    assign byte_ready = ~active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            tx      <= LINE_IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (!active) begin
            if (byte_valid) begin
                active  <= 1'b1;
                tx      <= ~LINE_IDLE;
                cyc_cnt <= '0;
                bit_cnt <= '0;
                shreg   <= {LINE_IDLE, byte_data};
            end
        end else if (cyc_cnt == CYC_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
                active <= 1'b0;
                tx     <= LINE_IDLE;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx      <= shreg[0];
                shreg   <= {LINE_IDLE, shreg[DATA_BITS:1]};
            end
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_dump_tx.sv
// Dumps a block of 32-bit memory words over UART 8N1, little-endian bytes per word.
// Define DUMP_CHECKSUM_EN to append one XOR-of-all-data-bytes trailer before done.
module uart_dump_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 10000000,
    parameter int BAUD     = 128000,
    parameter int ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_cnt,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int DIV = CLK_FREQ / BAUD;

    dump_state_e          state;
    logic [ADDR_W-1:0]    addr;
    logic [ADDR_W-1:0]    remaining;
    logic [31:0]          word_sr;
    logic [1:0]           byte_idx;
    logic                 byte_valid;
    logic [DATA_BITS-1:0] byte_data;
    logic                 byte_ready;
    logic                 xfer;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_BITS-1:0] csum;
`endif

    always_comb begin
        byte_valid = (state == ST_SEND);
        byte_data  = word_sr[DATA_BITS-1:0];
`ifdef DUMP_CHECKSUM_EN
        if (state == ST_CSUM) begin
            byte_valid = 1'b1;
            byte_data  = csum;
        end
`endif
    end

    assign xfer = byte_valid & byte_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            word_sr   <= '0;
            byte_idx  <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= word_cnt;
                        busy      <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        csum      <= '0;
`endif
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (remaining == '0) begin
`ifdef DUMP_CHECKSUM_EN
                        state <= ST_CSUM;
`else
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_FINISH;
`endif
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= addr;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    mem_rd_en <= 1'b0;
                    state     <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    word_sr  <= mem_rdata;
                    byte_idx <= '0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (xfer) begin
                        word_sr  <= word_sr >> DATA_BITS;
                        byte_idx <= byte_idx + 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        csum     <= csum ^ byte_data;
`endif
                        if (byte_idx == 2'd3)
                            state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - ADDR_W'(1);
                    state     <= ST_CHECK;
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
`ifdef DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_FINISH;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_tx_byte (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .tx         (tx)
    );

endmodule
